mem_port_arbiter: RTL and testbench

- Shares the CPU's single-port word RAM between two requesters: the instruction-fetch port (FETCH state) and the data port (load/store execution).
- Sits between the core FSM and the RAM.
- Serialises accesses with one outstanding transaction at a time.
- Uses data-first priority, with a starvation guard so fetch always makes progress.

---
 rtl/mem_port_arbiter.sv | 256 +++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-port word RAM between the instruction-fetch
// port and the data port. One transaction in flight at a time, data-first
// priority with a starvation guard that forces a fetch grant after MAX_STARVE
// consecutive data grants while fetch is waiting.
// Optional build macro: ARB_STATS_EN adds saturating grant/stall counters.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    // RAM port
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       if_grant_cnt,
    output logic [31:0]       d_grant_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int unsigned STARVE_W = 4;
    localparam int unsigned BE_W     = 4;
    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(MAX_STARVE);
    localparam logic [BE_W-1:0]     BE_FULL      = BE_W'(4'hF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    // set once the RAM response has been captured; rvalid goes out next cycle
    logic                resp_q, resp_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;

    logic                mem_req_d;
    logic                mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_d;
    logic [BE_W-1:0]     mem_be_d;
    logic                if_gnt_d;
    logic                d_gnt_d;
    logic                if_rvalid_d;
    logic                d_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_d;

    logic                pick_if;
    logic                pick_d;

    // Arbitration: data first unless fetch has waited out MAX_STARVE data grants
    always_comb begin
        pick_if = 1'b0;
        pick_d  = 1'b0;
        if (if_req && (!d_req || (starve_q == STARVE_LIMIT))) begin
            pick_if = 1'b1;
        end else if (d_req) begin
            pick_d = 1'b1;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        resp_d      = resp_q;
        resp_data_d = resp_data_q;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_be_d    = mem_be;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata;
        d_rdata_d   = d_rdata;

        // fetch not waiting: nothing to protect from starvation
        if (!if_req) begin
            starve_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (pick_if) begin
                    owner_d     = OWN_IF;
                    state_d     = ISSUE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = BE_FULL;
                    starve_d    = '0;
                end else if (pick_d) begin
                    owner_d     = OWN_D;
                    state_d     = ISSUE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_be_d    = d_be;
                    if (if_req && (starve_q < STARVE_LIMIT)) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end
            end

            ISSUE: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = WAIT;
                    if (owner_q == OWN_IF) begin
                        if_gnt_d = 1'b1;
                    end else begin
                        d_gnt_d = 1'b1;
                    end
                end
            end

            WAIT: begin
                if (resp_q) begin
                    resp_d  = 1'b0;
                    owner_d = OWN_NONE;
                    state_d = IDLE;
                    if (owner_q == OWN_IF) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = resp_data_q;
                    end else begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = resp_data_q;
                    end
                end else if (mem_rvalid) begin
                    resp_d = 1'b1;
                    // stores report zero data back to the core
                    if ((owner_q == OWN_D) && mem_we) begin
                        resp_data_d = '0;
                    end else begin
                        resp_data_d = mem_rdata;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
                resp_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            starve_q    <= '0;
            resp_q      <= 1'b0;
            resp_data_q <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            if_gnt      <= 1'b0;
            d_gnt       <= 1'b0;
            if_rvalid   <= 1'b0;
            d_rvalid    <= 1'b0;
            if_rdata    <= '0;
            d_rdata     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            resp_q      <= resp_d;
            resp_data_q <= resp_data_d;
            mem_req     <= mem_req_d;
            mem_we      <= mem_we_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            mem_be      <= mem_be_d;
            if_gnt      <= if_gnt_d;
            d_gnt       <= d_gnt_d;
            if_rvalid   <= if_rvalid_d;
            d_rvalid    <= d_rvalid_d;
            if_rdata    <= if_rdata_d;
            d_rdata     <= d_rdata_d;
        end
    end

`ifdef ARB_STATS_EN
    localparam int unsigned STAT_W = 32;

    logic stall_now;

    // A requester is waiting but no grant pulse is visible this cycle
    always_comb begin
        stall_now = (if_req || d_req) && !if_gnt && !d_gnt;
    end

    // Saturating grant and stall counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_grant_cnt <= '0;
            d_grant_cnt  <= '0;
            stall_cnt    <= '0;
        end else begin
            if (if_gnt_d && (if_grant_cnt != '1)) begin
                if_grant_cnt <= if_grant_cnt + STAT_W'(1);
            end
            if (d_gnt_d && (d_grant_cnt != '1)) begin
                d_grant_cnt <= d_grant_cnt + STAT_W'(1);
            end
            if (stall_now && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a single-cycle RAM model.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
`ifdef ARB_STATS_EN
    logic [31:0]       if_grant_cnt;
    logic [31:0]       d_grant_cnt;
    logic [31:0]       stall_cnt;
`endif

    // RAM model controls
    logic [DATA_W-1:0] ram_word;
    logic              ram_mute;
    logic              inject;
    logic              pending;

    int n_checks;
    int n_pass;
    bit glog[$];

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_STARVE(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ready (mem_ready),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
`ifdef ARB_STATS_EN
        ,
        .if_grant_cnt(if_grant_cnt),
        .d_grant_cnt (d_grant_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // RAM: answers one cycle after an accepted request (mem_req && mem_ready)
    always @(negedge clk) begin
        mem_rvalid = pending || inject;
        mem_rdata  = (pending || inject) ? ram_word : '0;
        pending    = mem_req && mem_ready && !ram_mute;
    end

    // Grant log and per-cycle exclusivity of the two ports
    always @(posedge clk) begin
        #1;
        if (if_gnt || d_gnt) begin
            check("gnt_excl", 64'(if_gnt && d_gnt), 64'd0);
            glog.push_back(if_gnt);
        end
        if (if_rvalid || d_rvalid) begin
            check("rvalid_excl", 64'(if_rvalid && d_rvalid), 64'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        pending   = 1'b0;
        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_be      = '0;
        mem_ready = 1'b1;
        ram_word  = '0;
        ram_mute  = 1'b0;
        inject    = 1'b0;

        // reset state
        tick();
        tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_if_gnt", if_gnt, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        check("rst_mem_be", mem_be, 0);
        rst_n = 1'b1;
        tick();

        // fetch alone
        ram_word = 32'h0050_0093;
        if_req   = 1'b1;
        if_addr  = 32'h10;
        tick();
        check("fetch_mem_req", mem_req, 1);
        check("fetch_mem_addr", mem_addr, 32'h10);
        check("fetch_mem_be", mem_be, 4'hF);
        check("fetch_mem_we", mem_we, 0);
        check("fetch_gnt_early", if_gnt, 0);
        tick();
        check("fetch_gnt", if_gnt, 1);
        check("fetch_mem_req_drop", mem_req, 0);
        if_req = 1'b0;
        tick();
        check("fetch_rvalid_early", if_rvalid, 0);
        tick();
        check("fetch_rvalid", if_rvalid, 1);
        check("fetch_rdata", if_rdata, 32'h0050_0093);
        check("fetch_no_d_rvalid", d_rvalid, 0);
        tick();
        check("fetch_rvalid_pulse", if_rvalid, 0);

        // store alone
        ram_word = 32'h1234_5678;
        d_req    = 1'b1;
        d_we     = 1'b1;
        d_addr   = 32'h40;
        d_wdata  = 32'hDEAD_BEEF;
        d_be     = 4'h3;
        tick();
        check("st_mem_req", mem_req, 1);
        check("st_mem_we", mem_we, 1);
        check("st_mem_addr", mem_addr, 32'h40);
        check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("st_mem_be", mem_be, 4'h3);
        tick();
        check("st_gnt", d_gnt, 1);
        check("st_no_if_gnt", if_gnt, 0);
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();
        tick();
        check("st_rvalid", d_rvalid, 1);
        check("st_rdata_zero", d_rdata, 0);
        tick();

        // RAM backpressure, plus a stray mem_rvalid while in ISSUE
        mem_ready = 1'b0;
        ram_word  = 32'hCAFE_0001;
        d_req     = 1'b1;
        d_addr    = 32'h80;
        d_be      = 4'hF;
        tick();
        check("bp_mem_req_e1", mem_req, 1);
        inject = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) inject = 1'b0;
            check("bp_mem_req_held", mem_req, 1);
            check("bp_mem_addr_held", mem_addr, 32'h80);
            check("bp_no_gnt", d_gnt, 0);
            check("bp_no_rvalid", d_rvalid, 0);
        end
        mem_ready = 1'b1;
        tick();
        check("bp_gnt", d_gnt, 1);
        check("bp_mem_req_drop", mem_req, 0);
        d_req = 1'b0;
        tick();
        check("bp_gnt_pulse", d_gnt, 0);
        tick();
        check("bp_rvalid", d_rvalid, 1);
        check("bp_rdata", d_rdata, 32'hCAFE_0001);

        // new request raised in the rvalid cycle is arbitrated on the next IDLE edge
        if_req  = 1'b1;
        if_addr = 32'h24;
        tick();
        check("back2back_mem_req", mem_req, 1);
        check("back2back_mem_addr", mem_addr, 32'h24);
        tick();
        check("back2back_gnt", if_gnt, 1);
        if_req = 1'b0;
        tick();
        tick();
        check("back2back_rvalid", if_rvalid, 1);
        check("back2back_rdata", if_rdata, 32'hCAFE_0001);
        tick();

        // reset while waiting for the RAM, then a late mem_rvalid
        ram_mute = 1'b1;
        if_req   = 1'b1;
        if_addr  = 32'h20;
        tick();
        tick();
        check("rw_gnt", if_gnt, 1);
        if_req = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("rw_mem_req", mem_req, 0);
        check("rw_mem_addr", mem_addr, 0);
        check("rw_if_rdata", if_rdata, 0);
        rst_n    = 1'b1;
        inject   = 1'b1;
        ram_mute = 1'b0;
        ram_word = 32'h0BAD_F00D;
        tick();
        inject = 1'b0;
        check("rw_no_rvalid_a", if_rvalid, 0);
        tick();
        check("rw_no_rvalid_b", if_rvalid, 0);
        check("rw_idle_mem_req", mem_req, 0);
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h44;
        tick();
        check("rw_next_mem_addr", mem_addr, 32'h44);
        tick();
        check("rw_next_gnt", d_gnt, 1);
        d_req = 1'b0;
        tick();
        tick();
        check("rw_next_rvalid", d_rvalid, 1);
        check("rw_next_rdata", d_rdata, 32'h0BAD_F00D);
        tick();

        // contention with both requests held: D D D D I D D D D I
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        glog.delete();
        ram_word = 32'h0000_0A0A;
        if_req   = 1'b1;
        if_addr  = 32'h100;
        d_req    = 1'b1;
        d_we     = 1'b0;
        d_addr   = 32'h200;
        for (int c = 0; c < 80 && glog.size() < 10; c++) begin
            tick();
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (6) tick();
        check("cont_count", 64'(glog.size()), 64'd10);
        for (int k = 0; k < 10; k++) begin
            bit want_if;
            want_if = (k == 4) || (k == 9);
            check("cont_order", 64'((k < glog.size()) ? glog[k] : 1'bx), 64'(want_if));
        end
`ifdef ARB_STATS_EN
        check("stats_d_grants", d_grant_cnt, 32'd8);
        check("stats_if_grants", if_grant_cnt, 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
